ps2_frame_shifter: RTL
======================

Name: ps2_frame_shifter

Overview:
- Parametrised PS/2 serial frame engine; sits between the PS/2 clock edge detector and the mouse/keyboard protocol FSM.
- Shifts a host-to-device command frame out and assembles multi-frame device packets (NFRAMES x 11-bit frames).
- Checks start, stop and odd parity on every received frame, and reports the decoded packet with a one-cycle valid strobe.
- A watchdog resynchronises the bit counter when the PS/2 clock stalls mid-packet.

Parameters:
NFRAMES, 3, number of 11-bit frames per received packet (1..8)
DATA_W, 8, payload bits per frame; frame width FW = DATA_W+3
TIMEOUT, 50000, clk cycles without falling_edge, mid-packet, before the counter is discarded
Derived: TOT = NFRAMES*FW; CW = clog2(TOT+1)

Ports:
clk  in  1  system clock; all state is updated on its rising edge
reset  in  1  synchronous, active-high reset
falling_edge  in  1  one-clk strobe marking a PS/2 clock falling edge
din  in  1  synchronised PS/2 data sample, valid when falling_edge=1
load  in  1  load a TX command frame from tx_data
tx_data  in  DATA_W  command payload
clear  in  1  abort the current RX packet; clears the counter and error flags
q  out  TOT  raw shift register
tx_bit  out  1  q[0]; drives the PS/2 data line in TX mode
bit_cnt  out  CW  bits shifted since the last load, packet or clear
tx_active  out  1  1 while in TX mode
tx_done  out  1  one-clk pulse after the FW-th TX shift
pkt_valid  out  1  one-clk pulse: packet decoded
pkt_data  out  NFRAMES*DATA_W  frame k payload at [k*DATA_W +: DATA_W]; frame 0 is received first
parity_err  out  NFRAMES  per-frame odd-parity failure, latched with pkt_valid
frame_err  out  NFRAMES  per-frame start!=0 or stop!=1, latched with pkt_valid

Behaviour:
- Reset values: q = all ones (line idle high); bit_cnt=0; mode=RX; tx_active=0; tx_done=0; pkt_valid=0; pkt_data=0; parity_err=0; frame_err=0; watchdog=0.
- Priority each clk: reset > load > clear > falling_edge. A falling_edge coinciding with load or clear is dropped.
- load:
  - q[FW-1:0] = {1 (stop), ~^tx_data (odd parity), tx_data, 0 (start)}; q[TOT-1:FW] = all ones.
  - bit_cnt=0; mode=TX; tx_active=1.
- clear: bit_cnt=0; mode=RX; parity_err and frame_err cleared; q unchanged.
- Shift, on every accepted falling_edge in either mode: q <= {din, q[TOT-1:1]}; bit_cnt increments.
- TX mode:
  - On the shift that makes bit_cnt==FW: tx_done=1 the next clk (one cycle), mode=RX, tx_active=0, bit_cnt=0.
  - q is not cleared on this transition; the next received packet overwrites it.
- RX mode, on the shift that makes bit_cnt==TOT:
  - Decode is taken from the post-shift register value.
  - Frame k = q[k*FW +: FW]: start = bit 0, data = bits DATA_W:1, parity = bit DATA_W+1, stop = bit FW-1.
  - parity_err[k] = ~^{data, parity}. frame_err[k] = start | ~stop.
  - pkt_data, parity_err and frame_err register on that edge; pkt_valid=1 the following clk for exactly one cycle.
  - Latency: the last falling_edge strobe at cycle n gives pkt_valid at cycle n+1.
  - bit_cnt returns to 0, so back-to-back packets need no gap.
  - pkt_data and the error flags hold until the next packet or reset; clear zeroes only the error flags.
- Watchdog:
  - Counts clk cycles while bit_cnt!=0 and there is no falling_edge; it is reset by every accepted edge.
  - On reaching TIMEOUT: bit_cnt=0, mode=RX, tx_active=0, no pkt_valid, no tx_done; q unchanged.
  - Held at 0 while bit_cnt==0.
- reset asserted mid-packet or mid-TX aborts immediately to the reset values; no pulse is emitted.
- pkt_valid and tx_done are never high in the same cycle.

Test Plan:
- Reset, then load with tx_data=0xF4 -> q[10:0]=0x5E8, upper q bits all ones, tx_bit=0, tx_active=1; 11 falling_edge strobes with din=1 -> tx_done pulses once at strobe 11 +1 clk, tx_active=0, bit_cnt=0.
- RX packet with NFRAMES=3, frames 0x08, 0x01, 0xFF sent with correct parity (0, 0, 1) -> pkt_valid for exactly one clk, 1 clk after the 33rd strobe; pkt_data=0xFF0108, parity_err=0, frame_err=0.
- Same packet with frame 1 parity inverted and frame 2 stop=0 -> parity_err=3'b010, frame_err=3'b100, pkt_data=0xFF0108.
- Two packets back-to-back, with the first strobe of packet 2 on the clk right after pkt_valid of packet 1 -> two pkt_valid pulses, both payloads correct.
- TIMEOUT=20; 5 strobes, then 20 idle clks -> bit_cnt=0 with no pulse; the following full packet decodes correctly.
- load coinciding with falling_edge mid-RX (bit_cnt=12) -> edge dropped, bit_cnt=0, tx_active=1; reset asserted at bit_cnt=7 of TX -> every output returns to its reset value the next clk.

Source files
------------

// File: rtl/ps2_frame_shifter.sv
// PS/2 frame engine: shifts one host-to-device command frame out and assembles
// NFRAMES-frame device packets, checking start, stop and odd parity per frame.
module ps2_frame_shifter #(
   parameter int unsigned NFRAMES = 3,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 50000,
   localparam int unsigned FW  = DATA_W + 3,
   localparam int unsigned TOT = NFRAMES * FW,
   localparam int unsigned CW  = $clog2(TOT + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      falling_edge,
   input  logic                      din,
   input  logic                      load,
   input  logic [DATA_W-1:0]         tx_data,
   input  logic                      clear,
   output logic [TOT-1:0]            q,
   output logic                      tx_bit,
   output logic [CW-1:0]             bit_cnt,
   output logic                      tx_active,
   output logic                      tx_done,
   output logic                      pkt_valid,
   output logic [NFRAMES*DATA_W-1:0] pkt_data,
   output logic [NFRAMES-1:0]        parity_err,
   output logic [NFRAMES-1:0]        frame_err
);

   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FwCnt  = CW'(FW);
   localparam logic [CW-1:0] TotCnt = CW'(TOT);
   localparam logic [WW-1:0] WdMax  = WW'(TIMEOUT - 1);

   localparam logic ModeRx = 1'b0;
   localparam logic ModeTx = 1'b1;

   logic                      mode;
   logic [WW-1:0]             wd;
   logic [TOT-1:0]            q_shift;
   logic [TOT-1:0]            q_load;
   logic [CW-1:0]             cnt_inc;
   logic [NFRAMES*DATA_W-1:0] dec_data;
   logic [NFRAMES-1:0]        dec_perr;
   logic [NFRAMES-1:0]        dec_ferr;

   assign tx_bit    = q[0];
   assign tx_active = (mode == ModeTx);

   // Decode is taken from the value the register will hold after this shift.
   always_comb begin
      q_shift = {din, q[TOT-1:1]};
      cnt_inc = bit_cnt + 1'b1;
      q_load  = '1;
      q_load[FW-1:0] = {1'b1, ~^tx_data, tx_data, 1'b0};
      dec_data = '0;
      dec_perr = '0;
      dec_ferr = '0;
      for (int k = 0; k < int'(NFRAMES); k++) begin
         dec_data[k*DATA_W +: DATA_W] = q_shift[k*FW + 1 +: DATA_W];
         dec_perr[k] = ~^q_shift[k*FW + 1 +: DATA_W + 1];
         dec_ferr[k] = q_shift[k*FW] | ~q_shift[k*FW + FW - 1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q          <= '1;
         bit_cnt    <= '0;
         mode       <= ModeRx;
         tx_done    <= 1'b0;
         pkt_valid  <= 1'b0;
         pkt_data   <= '0;
         parity_err <= '0;
         frame_err  <= '0;
         wd         <= '0;
      end else begin
         tx_done   <= 1'b0;
         pkt_valid <= 1'b0;
         if (load) begin
            q       <= q_load;
            bit_cnt <= '0;
            mode    <= ModeTx;
            wd      <= '0;
         end else if (clear) begin
            bit_cnt    <= '0;
            mode       <= ModeRx;
            parity_err <= '0;
            frame_err  <= '0;
            wd         <= '0;
         end else if (falling_edge) begin
            q  <= q_shift;
            wd <= '0;
            if (mode == ModeTx) begin
               if (cnt_inc == FwCnt) begin
                  tx_done <= 1'b1;
                  mode    <= ModeRx;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= cnt_inc;
               end
            end else if (cnt_inc == TotCnt) begin
               pkt_valid  <= 1'b1;
               pkt_data   <= dec_data;
               parity_err <= dec_perr;
               frame_err  <= dec_ferr;
               bit_cnt    <= '0;
            end else begin
               bit_cnt <= cnt_inc;
            end
         end else if (bit_cnt != '0) begin
            // Stalled PS/2 clock: drop the partial frame, keep q as-is.
            if (wd == WdMax) begin
               bit_cnt <= '0;
               mode    <= ModeRx;
               wd      <= '0;
            end else begin
               wd <= wd + 1'b1;
            end
         end else begin
            wd <= '0;
         end
      end
   end

endmodule
